// File: rtl/power_mode_ctrl_pkg.sv
// Shared definitions for the power and drive-mode controller: FSM states,
// mode encodings and the mode validity check.
package power_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    PWR_OFF          = 2'd0,
    PWR_ARMING       = 2'd1,
    PWR_ON           = 2'd2,
    PWR_WAIT_RELEASE = 2'd3
  } pwr_state_e;

  localparam logic [2:0] MODE_NONE   = 3'b000;
  localparam logic [2:0] MODE_MANUAL = 3'b001;
  localparam logic [2:0] MODE_SEMI   = 3'b010;
  localparam logic [2:0] MODE_AUTO   = 3'b100;

  function automatic logic is_valid_mode(input logic [2:0] mode);
    return (mode == MODE_MANUAL) || (mode == MODE_SEMI) || (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/power_mode_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a tick-paced debouncer for one raw input.
// The output follows the synced value only after DEBOUNCE_TICKS consecutive differing ticks.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (tick) begin
      if (sync2_q != db_q) begin
        // Reaching the threshold on this tick commits the new value at once.
        if (cnt_q == CNT_LAST) begin
          db_d  = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/power_mode_ctrl.sv
// Power and drive-mode front end: debounced buttons, press-and-hold power-up,
// forced shutdown and one-hot mode latching, all outputs registered.
module power_mode_ctrl
  import power_mode_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned HOLD_TICKS     = 1000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       power_on_btn,
  input  logic       power_off_btn,
  input  logic [2:0] mode_sw,
  input  logic       power_kill,
  output logic       power_state,
  output logic       power_up_pulse,
  output logic [2:0] mode_onehot,
  output logic       power_led,
  output logic [2:0] mode_led
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  logic          tick;
  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;

  logic          on_db;
  logic          off_db;
  logic [2:0]    mode_db;

  pwr_state_e    state_q;
  pwr_state_e    state_d;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic [HW-1:0] hold_inc;
  logic          power_state_q;
  logic          power_state_d;
  logic          power_up_pulse_q;
  logic          power_up_pulse_d;
  logic [2:0]    mode_onehot_q;
  logic [2:0]    mode_onehot_d;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_on (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .tick  (tick),
    .din   (power_on_btn),
    .dout  (on_db)
  );

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_off (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .tick  (tick),
    .din   (power_off_btn),
    .dout  (off_db)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_mode_db
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .tick  (tick),
      .din   (mode_sw[gi]),
      .dout  (mode_db[gi])
    );
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_comb begin
    state_d          = state_q;
    hold_cnt_d       = hold_cnt_q;
    power_up_pulse_d = 1'b0;
    hold_inc         = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HW'(1);

    unique case (state_q)
      PWR_OFF: begin
        if (on_db && !off_db) begin
          state_d    = PWR_ARMING;
          hold_cnt_d = '0;
        end
      end
      PWR_ARMING: begin
        // Kill and off both outrank a held power-on, so arming aborts on either.
        if (power_kill || off_db || !on_db) begin
          state_d = PWR_OFF;
        end else if (tick) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == HOLD_MAX) begin
            state_d          = PWR_ON;
            power_up_pulse_d = 1'b1;
          end
        end
      end
      PWR_ON: begin
        if (power_kill || off_db) begin
          state_d = PWR_WAIT_RELEASE;
        end
      end
      PWR_WAIT_RELEASE: begin
        if (!on_db && !off_db) begin
          state_d = PWR_OFF;
        end
      end
      default: state_d = PWR_OFF;
    endcase

    // Outputs are registered from the next state so they change with it.
    power_state_d = (state_d == PWR_ON);
    mode_onehot_d = (power_state_d && is_valid_mode(mode_db)) ? mode_db : MODE_NONE;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q       <= '0;
      state_q          <= PWR_OFF;
      hold_cnt_q       <= '0;
      power_state_q    <= 1'b0;
      power_up_pulse_q <= 1'b0;
      mode_onehot_q    <= MODE_NONE;
    end else begin
      tick_cnt_q       <= tick_cnt_d;
      state_q          <= state_d;
      hold_cnt_q       <= hold_cnt_d;
      power_state_q    <= power_state_d;
      power_up_pulse_q <= power_up_pulse_d;
      mode_onehot_q    <= mode_onehot_d;
    end
  end

  assign power_state    = power_state_q;
  assign power_up_pulse = power_up_pulse_q;
  assign mode_onehot    = mode_onehot_q;
  assign power_led      = power_state_q;
  assign mode_led       = mode_onehot_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Bench for power_mode_ctrl: directed scenarios plus random button/mode/kill
// traffic, checked every cycle against a behavioural model.
module tb_power_mode_ctrl;
  import power_mode_ctrl_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int HOLD     = 10;

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_ARM  = 2'd1;
  localparam logic [1:0] M_ON   = 2'd2;
  localparam logic [1:0] M_WAIT = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       power_on_btn;
  logic       power_off_btn;
  logic [2:0] mode_sw;
  logic       power_kill;
  logic       power_state;
  logic       power_up_pulse;
  logic [2:0] mode_onehot;
  logic       power_led;
  logic [2:0] mode_led;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_total = 0;

  power_mode_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HOLD)
  ) dut (
    .sys_clk        (clk),
    .rst_n          (rst_n),
    .power_on_btn   (power_on_btn),
    .power_off_btn  (power_off_btn),
    .mode_sw        (mode_sw),
    .power_kill     (power_kill),
    .power_state    (power_state),
    .power_up_pulse (power_up_pulse),
    .mode_onehot    (mode_onehot),
    .power_led      (power_led),
    .mode_led       (mode_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: bit 0 = power-on, bit 1 = power-off, bits 4:2 = mode switches.
  typedef struct packed {
    logic [1:0]      ph;
    logic [15:0]     hold;
    logic            pulse;
    logic            pwr;
    logic [2:0]      mode;
    logic [4:0]      s1;
    logic [4:0]      s2;
    logic [4:0]      db;
    logic [4:0][3:0] cnt;
    logic [31:0]     cyc;
  } model_t;

  model_t m = '0;

  function automatic model_t model_next(input model_t c, input logic [4:0] raw, input logic kill);
    model_t n;
    logic tick;
    logic on;
    logic off;
    logic [2:0] dm;
    n    = c;
    tick = ((c.cyc % TICK_DIV) == TICK_DIV - 1);
    on   = c.db[0];
    off  = c.db[1];
    dm   = c.db[4:2];
    n.pulse = 1'b0;
    case (c.ph)
      M_OFF: if (on && !off) begin n.ph = M_ARM; n.hold = 16'd0; end
      M_ARM: begin
        if (kill || off || !on) n.ph = M_OFF;
        else if (tick) begin
          n.hold = c.hold + 16'd1;
          if (n.hold == 16'(HOLD)) begin n.ph = M_ON; n.pulse = 1'b1; end
        end
      end
      M_ON:    if (kill || off) n.ph = M_WAIT;
      default: if (!on && !off) n.ph = M_OFF;
    endcase
    n.pwr  = (n.ph == M_ON);
    n.mode = (n.pwr && $countones(dm) == 1) ? dm : 3'b000;
    for (int i = 0; i < 5; i++) begin
      if (tick) begin
        if (c.s2[i] != c.db[i]) begin
          if (c.cnt[i] + 4'd1 == 4'(DEB)) begin n.db[i] = c.s2[i]; n.cnt[i] = 4'd0; end
          else n.cnt[i] = c.cnt[i] + 4'd1;
        end else n.cnt[i] = 4'd0;
      end
    end
    n.s2  = c.s1;
    n.s1  = raw;
    n.cyc = c.cyc + 32'd1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= model_next(m, {mode_sw, power_off_btn, power_on_btn}, power_kill);
  end

  always @(negedge clk) begin
    check("cyc_power_state", 32'(power_state), 32'(m.pwr));
    check("cyc_pulse", 32'(power_up_pulse), 32'(m.pulse));
    check("cyc_mode", 32'(mode_onehot), 32'(m.mode));
    check("cyc_power_led", 32'(power_led), 32'(m.pwr));
    check("cyc_mode_led", 32'(mode_led), 32'(m.mode));
    if (power_up_pulse) pulse_total++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    wait_cycles(n * TICK_DIV);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_power_state", 32'(power_state), 32'd0);
    check("rst_pulse", 32'(power_up_pulse), 32'd0);
    check("rst_mode", 32'(mode_onehot), 32'd0);
    check("rst_power_led", 32'(power_led), 32'd0);
    check("rst_mode_led", 32'(mode_led), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic go_off();
    power_on_btn  = 1'b0;
    power_off_btn = 1'b1;
    wait_ticks(6);
    power_off_btn = 1'b0;
    wait_ticks(6);
    check("go_off_power", 32'(power_state), 32'd0);
    check("go_off_fsm", 32'(dut.state_q), 32'(PWR_OFF));
  endtask

  task automatic power_up(input string tag);
    int budget;
    budget = 30 * TICK_DIV;
    power_on_btn = 1'b1;
    while (!power_state && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(power_state), 32'd1);
    power_on_btn = 1'b0;
  endtask

  initial begin
    int p0;
    int budget;
    rst_n         = 1'b0;
    power_on_btn  = 1'b0;
    power_off_btn = 1'b0;
    mode_sw       = 3'b000;
    power_kill    = 1'b0;
    wait_cycles(3);
    check("init_power_state", 32'(power_state), 32'd0);
    check("init_mode", 32'(mode_onehot), 32'd0);
    check("init_fsm", 32'(dut.state_q), 32'(PWR_OFF));
    rst_n = 1'b1;

    // Hold to power up
    p0 = pulse_total;
    power_on_btn = 1'b1;
    wait_ticks(20);
    check("hold_power", 32'(power_state), 32'd1);
    check("hold_pulses", 32'(pulse_total - p0), 32'd1);
    check("hold_mode", 32'(mode_onehot), 32'd0);
    go_off();

    // Short press
    p0 = pulse_total;
    power_on_btn = 1'b1;
    wait_ticks(8);
    power_on_btn = 1'b0;
    wait_ticks(8);
    check("short_power", 32'(power_state), 32'd0);
    check("short_pulses", 32'(pulse_total - p0), 32'd0);
    check("short_fsm", 32'(dut.state_q), 32'(PWR_OFF));

    // Mode latching and bounce
    power_up("mode_power_up");
    mode_sw = 3'b010;
    wait_ticks(6);
    check("mode_semi", 32'(mode_onehot), 32'(MODE_SEMI));
    check("mode_led_semi", 32'(mode_led), 32'(MODE_SEMI));
    mode_sw = 3'b011;
    wait_ticks(6);
    check("mode_invalid", 32'(mode_onehot), 32'(MODE_NONE));
    mode_sw = 3'b010;
    wait_ticks(6);
    mode_sw = 3'b100;
    wait_ticks(2);
    mode_sw = 3'b010;
    wait_ticks(6);
    check("mode_glitch", 32'(mode_onehot), 32'(MODE_SEMI));

    // power_kill while power-on is held
    power_on_btn = 1'b1;
    wait_ticks(6);
    check("kill_before", 32'(power_state), 32'd1);
    power_kill = 1'b1;
    @(negedge clk);
    power_kill = 1'b0;
    check("kill_next_cycle", 32'(power_state), 32'd0);
    check("kill_mode", 32'(mode_onehot), 32'd0);
    p0 = pulse_total;
    wait_ticks(20);
    check("kill_held_off", 32'(power_state), 32'd0);
    check("kill_held_pulses", 32'(pulse_total - p0), 32'd0);
    power_on_btn = 1'b0;
    wait_ticks(6);
    check("kill_release_fsm", 32'(dut.state_q), 32'(PWR_OFF));
    power_on_btn = 1'b1;
    wait_ticks(8);
    check("kill_repress_early", 32'(power_state), 32'd0);
    wait_ticks(12);
    check("kill_repress_full", 32'(power_state), 32'd1);
    go_off();

    // Both buttons
    p0 = pulse_total;
    power_on_btn  = 1'b1;
    power_off_btn = 1'b1;
    wait_ticks(20);
    check("both_power", 32'(power_state), 32'd0);
    check("both_pulses", 32'(pulse_total - p0), 32'd0);
    power_on_btn  = 1'b0;
    power_off_btn = 1'b0;
    wait_ticks(6);
    check("both_release_fsm", 32'(dut.state_q), 32'(PWR_OFF));

    // Reset mid-arm at hold_cnt = 7
    power_on_btn = 1'b1;
    budget = 30 * TICK_DIV;
    while (!(m.ph == M_ARM && m.hold == 16'd7) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("arm_reach_hold7", 32'(dut.hold_cnt_q), 32'd7);
    pulse_reset();
    check("arm_fsm_after_rst", 32'(dut.state_q), 32'(PWR_OFF));
    wait_ticks(11);
    check("arm_not_yet", 32'(power_state), 32'd0);
    wait_ticks(3);
    check("arm_full_hold", 32'(power_state), 32'd1);
    go_off();

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      int dur;
      power_on_btn  = ($urandom_range(0, 3) != 0);
      power_off_btn = ($urandom_range(0, 4) == 0);
      mode_sw       = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 16) * TICK_DIV;
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        power_kill = ($urandom_range(0, 63) == 0);
      end
      power_kill = 1'b0;
      if ($urandom_range(0, 19) == 0) pulse_reset();
    end
    power_on_btn  = 1'b0;
    power_off_btn = 1'b0;
    wait_ticks(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
